// File: rtl/cp0_pkg.sv
// Shared CPU constants: coprocessor-0 register indices, exception vector,
// processor ID and exception codes.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE       = 32'h2019_1221;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt/exception request
// generation and EPC capture for the M stage.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_m,
    input  logic        BD_m,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        eret_d,
    output logic [31:0] DOut,
    output logic [31:0] EPC,
    output logic [31:0] exception_handler,
    output logic        interrupt,
    output logic        exception
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:2] epc_q;

    logic        take_event;
    logic [31:0] epc_src;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // An eret in D cancels any request so the handler return is not re-trapped.
    assign interrupt  = ie_q & ~exl_q & (|(HWInt & im_q)) & ~eret_d;
    assign exception  = (ExcCode_in != 5'd0) & ~exl_q & ~interrupt & ~eret_d;
    assign take_event = interrupt | exception;

    assign epc_src = BD_m ? (PC_m - 32'd4) : PC_m;

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

    assign EPC               = {epc_q, 2'b00};
    assign exception_handler = EXC_HANDLER_ADDR;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; later assignments in the block override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            ip_q <= HWInt;
            if (take_event) begin
                exl_q      <= 1'b1;
                epc_q      <= epc_src[31:2];
                bd_q       <= BD_m;
                exc_code_q <= interrupt ? EXC_INT : ExcCode_in;
            end else if (WE) begin
                if (A2 == CP0_SR) begin
                    im_q  <= DIn[15:10];
                    exl_q <= DIn[1];
                    ie_q  <= DIn[0];
                end else if (A2 == CP0_EPC) begin
                    epc_q <= DIn[31:2];
                end
            end
            // eret wins over a same-cycle mtc0 to SR for the EXL bit only.
            if (eret_d) begin
                exl_q <= 1'b0;
            end
        end
    end

    // NOTE: DOut gets a default before the case so no latch is inferred.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            CP0_SR:    DOut = sr_val;
            CP0_CAUSE: DOut = cause_val;
            CP0_EPC:   DOut = {epc_q, 2'b00};
            CP0_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a register-level model.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_m;
    logic        BD_m;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic        eret_d;
    logic [31:0] DOut;
    logic [31:0] EPC;
    logic [31:0] exception_handler;
    logic        interrupt;
    logic        exception;

    int n_vec = 0;
    int n_bad = 0;

    // Model state held as whole 32-bit register images.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    bit          model_valid = 1'b0;

    cp0 dut (
        .clk               (clk),
        .reset             (reset),
        .PC_m              (PC_m),
        .BD_m              (BD_m),
        .ExcCode_in        (ExcCode_in),
        .HWInt             (HWInt),
        .A1                (A1),
        .A2                (A2),
        .DIn               (DIn),
        .WE                (WE),
        .eret_d            (eret_d),
        .DOut              (DOut),
        .EPC               (EPC),
        .exception_handler (exception_handler),
        .interrupt         (interrupt),
        .exception         (exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_int();
        return m_sr[0] & ~m_sr[1] & (|(HWInt & m_sr[15:10])) & ~eret_d;
    endfunction

    function automatic logic exp_exc();
        return (ExcCode_in != 0) & ~m_sr[1] & ~exp_int() & ~eret_d;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2019_1221;
            default: return 32'd0;
        endcase
    endfunction

    // Model advances at each rising edge from the inputs held over the cycle.
    always @(posedge clk) begin
        logic ev_int;
        logic ev_exc;
        logic [31:0] ret;
        ev_int = exp_int();
        ev_exc = exp_exc();
        if (reset) begin
            m_sr        = 0;
            m_cause     = 0;
            m_epc       = 0;
            model_valid = 1'b1;
        end else begin
            m_cause[15:10] = HWInt;
            if (ev_int || ev_exc) begin
                ret      = BD_m ? PC_m - 4 : PC_m;
                m_epc    = ret & ~32'd3;
                m_sr[1]  = 1'b1;
                m_cause  = {BD_m, 15'd0, HWInt, 3'd0, (ev_int ? 5'd0 : ExcCode_in), 2'd0};
            end else if (WE) begin
                if (A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
                if (A2 == 5'd14) m_epc = DIn & ~32'd3;
            end
            if (eret_d) m_sr[1] = 1'b0;
        end
    end

    // Every cycle, mid-period, compare all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("interrupt", {31'd0, interrupt}, {31'd0, exp_int()});
            check("exception", {31'd0, exception}, {31'd0, exp_exc()});
            check("DOut", DOut, exp_read(A1));
            check("EPC", EPC, m_epc);
            check("handler", exception_handler, 32'h0000_4180);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PC_m = 0; BD_m = 0; ExcCode_in = 0; HWInt = 0;
        A1 = 0; A2 = 0; DIn = 0; WE = 0; eret_d = 0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_int", {31'd0, interrupt}, 32'd0);
        A1 = 5'd13; #1 check("rst_cause", DOut, 32'd0);

        // mtc0 SR then a masked-in hardware interrupt
        WE = 1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        WE = 0; HWInt = 6'b000100; PC_m = 32'h0000_3000; BD_m = 0;
        #1 check("int_req", {31'd0, interrupt}, 32'd1);
        tick();
        A1 = 5'd12; #1 check("sr_after_int", DOut, 32'h0000_FC03);
        check("epc_after_int", EPC, 32'h0000_3000);
        check("int_masked", {31'd0, interrupt}, 32'd0);
        A1 = 5'd13; #1 check("cause_after_int", DOut, 32'h0000_1000);

        // eret with interrupt still pending: re-raised the cycle after
        eret_d = 1; #1 check("int_eret_gate", {31'd0, interrupt}, 32'd0);
        tick();
        eret_d = 0; #1 check("int_after_eret", {31'd0, interrupt}, 32'd1);
        tick();
        HWInt = 0; eret_d = 1;
        tick();
        eret_d = 0;

        // overflow in a delay slot
        ExcCode_in = 5'd12; PC_m = 32'h0000_3010; BD_m = 1;
        #1 check("exc_req", {31'd0, exception}, 32'd1);
        tick();
        ExcCode_in = 0; BD_m = 0; A1 = 5'd14;
        #1 check("epc_bd", DOut, 32'h0000_300C);
        check("epc_out_bd", EPC, 32'h0000_300C);
        A1 = 5'd13; #1 check("cause_bd", DOut, 32'h8000_0030);
        eret_d = 1;
        tick();
        eret_d = 0;

        // interrupt beats a simultaneous RI exception
        HWInt = 6'b000100; ExcCode_in = 5'd10; PC_m = 32'h0000_3020;
        #1 check("prio_int", {31'd0, interrupt}, 32'd1);
        check("prio_exc", {31'd0, exception}, 32'd0);
        tick();
        ExcCode_in = 0; HWInt = 0; A1 = 5'd13;
        #1 check("prio_cause", DOut, 32'h0000_1000);
        eret_d = 1;
        tick();
        eret_d = 0;

        // mtc0 EPC drops low bits; PRId readback
        WE = 1; A2 = 5'd14; DIn = 32'h0000_3007;
        tick();
        WE = 0; #1 check("epc_write", EPC, 32'h0000_3004);
        A1 = 5'd15; #1 check("prid", DOut, 32'h2019_1221);

        // reset in the middle of a handler
        HWInt = 6'b000100; PC_m = 32'h0000_3040;
        tick();
        HWInt = 0; reset = 1;
        tick();
        reset = 0; A1 = 5'd12;
        #1 check("rst_sr", DOut, 32'd0);
        check("rst_epc", EPC, 32'd0);
        A1 = 5'd13; #1 check("rst_cause2", DOut, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            PC_m   = $urandom;
            BD_m   = 1'($urandom_range(0, 1));
            HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            eret_d = ($urandom_range(0, 7) == 0);
            WE     = ($urandom_range(0, 2) == 0);
            DIn    = $urandom;
            case ($urandom_range(0, 5))
                0:       ExcCode_in = 5'd4;
                1:       ExcCode_in = 5'd10;
                2:       ExcCode_in = 5'($urandom);
                default: ExcCode_in = 5'd0;
            endcase
            case ($urandom_range(0, 4))
                0, 1:    A2 = 5'd12;
                2:       A2 = 5'd14;
                3:       A2 = 5'd13;
                default: A2 = 5'($urandom);
            endcase
            A1 = 5'($urandom_range(10, 17));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port PC_m, input, 32, PC of instruction currently in M stage.
REQ-004 SHALL have port BD_m, input, 1, M-stage instruction sits in a branch delay slot.
REQ-005 SHALL have port ExcCode_in, input, 5, exception code from M stage; 0 = no exception.
REQ-006 SHALL have port HWInt, input, 6, level-sensitive hardware interrupt lines.
REQ-007 SHALL have port A1, input, 5, mfc0 read register index.
REQ-008 SHALL have port A2, input, 5, mtc0 write register index.
REQ-009 SHALL have port DIn, input, 32, mtc0 write data.
REQ-010 SHALL have port WE, input, 1, mtc0 write enable.
REQ-011 SHALL have port eret_d, input, 1, eret decoded in D stage.
REQ-012 SHALL have port DOut, output, 32, mfc0 read data.
REQ-013 SHALL have port EPC, output, 32, current EPC register value.
REQ-014 SHALL have port exception_handler, output, 32, constant 32'h0000_4180.
REQ-015 SHALL have port interrupt, output, 1, take-interrupt request this cycle.
REQ-016 SHALL have port exception, output, 1, take-exception request this cycle.

Function
REQ-017 SHALL implement SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
REQ-018 SHALL implement Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
REQ-019 SHALL implement EPC(14) with bits [1:0] always 0, and PRId(15) as read-only constant 32'h2019_1221.
REQ-020 SHALL load Cause.IP <= HWInt every cycle, regardless of EXL.
REQ-021 SHALL drive interrupt = IE & ~EXL & |(HWInt & IM) & ~eret_d, combinationally.
REQ-022 SHALL drive exception = (ExcCode_in != 0) & ~EXL & ~interrupt & ~eret_d, combinationally; interrupt has priority.
REQ-023 SHALL, on a cycle with interrupt or exception high, set EXL<=1; set EPC<=BD_m ? {PC_m-4}[31:2],00 : PC_m[31:2],00; set Cause.BD<=BD_m; set Cause.ExcCode<= interrupt ? 0 : ExcCode_in.
REQ-024 SHALL ignore WE in any cycle where interrupt or exception is high (event update wins).
REQ-025 SHALL, when eret_d high, clear EXL next edge; an mtc0 to SR in the same cycle writes IM/IE but EXL still ends 0.
REQ-026 SHALL, when WE high and no event, write: SR <= IM/EXL/IE from DIn; EPC <= {DIn[31:2],2'b00}; writes to Cause, PRId or unmapped indices have no effect.
REQ-027 SHALL drive DOut combinationally from the register at A1 (pre-edge value); unmapped index returns 0; same-cycle write is not forwarded.
REQ-028 SHALL present EPC output as the registered value, so a new EPC is visible the cycle after capture.
REQ-029 SHALL produce one request per event: once EXL=1, further interrupts/exceptions are masked until eret clears it.

Reset
REQ-030 SHALL, when reset high at an edge, clear SR, Cause and EPC to 0; interrupt and exception are 0 the following cycle.
REQ-031 SHALL give reset priority over eret_d, WE and event capture.

Structure
REQ-032 SHALL place register indices 12–15, handler address 32'h0000_4180, PRId value and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) in the shared CPU constants package.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL cover: mtc0 SR=32'h0000_FC01, HWInt=6'b000100 -> interrupt=1 same cycle; next cycle EXL=1, EPC=PC_m, Cause.ExcCode=0, interrupt=0.
REQ-035 SHALL cover: ExcCode_in=12, PC_m=32'h0000_3010, BD_m=1 -> exception=1; next cycle EPC=32'h0000_300C, Cause=32'h8000_0030.
REQ-036 SHALL cover: interrupt and ExcCode_in=10 together -> only interrupt=1, ExcCode recorded 0.
REQ-037 SHALL cover: EXL=1, eret_d=1 -> EXL=0 next cycle; pending HWInt then raises interrupt in that following cycle.
REQ-038 SHALL cover: WE=1, A2=14, DIn=32'h0000_3007 -> EPC=32'h0000_3004; A1=15 -> DOut=32'h2019_1221.
REQ-039 SHALL cover: reset asserted mid-handler (EXL=1, EPC nonzero) -> all registers 0 next cycle.
